// File: rtl/aes_sbox_pkg.sv
// rtl/aes_sbox_pkg.sv - shared GF(2^8) constants, FSM states and arithmetic helpers for the AES S-box blocks
package aes_sbox_pkg;

    localparam logic [7:0] GF_POLY  = 8'h1B;
    localparam logic [7:0] AFFINE_C = 8'h63;
    localparam logic [7:0] INV_EXP  = 8'hFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift-and-add multiply, folding GF_POLY back in whenever bit 7 shifts out.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gsq(input logic [7:0] a);
        return gmul(a, a);
    endfunction

endpackage

// File: rtl/affine_transform.sv
// rtl/affine_transform.sv - forward AES affine transform with encrypt gate for OR-merging with the decrypt path
module affine_transform
    import aes_sbox_pkg::*;
(
    input  logic [7:0] b,
    input  logic       encrypt,
    output logic [7:0] y
);

    logic [7:0] t;

    always_comb begin
        t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            t[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
                 ^ b[(i + 7) % 8] ^ AFFINE_C[i];
        end
    end

    // Zero when not encrypting so the inverse-affine result can be OR-ed in unchanged.
    assign y = encrypt ? t : 8'h00;

endmodule

// File: rtl/sbox_fwd_iter.sv
// rtl/sbox_fwd_iter.sv - iterative forward AES S-box: x^254 by square-and-multiply, then affine
module sbox_fwd_iter
    import aes_sbox_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] byte_in,
    input  logic       encrypt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] byte_out
);

    localparam int CALC_CYCLES = 8 / STEPS_PER_CYCLE;

    if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4 ||
          STEPS_PER_CYCLE == 8) || (CALC_CYCLES * STEPS_PER_CYCLE != 8)) begin : g_bad_steps
        $error("sbox_fwd_iter: STEPS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t     state;
    logic [7:0] x;
    logic       enc;
    logic [7:0] r;
    logic [2:0] k;
    logic [7:0] r_next;
    logic [2:0] bit_idx;
    logic [7:0] affine_out;
    logic       last_cycle;

    // Exponent bits are consumed MSB first, so k falls from 7 towards 0.
    always_comb begin
        r_next  = r;
        bit_idx = k;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            bit_idx = k - 3'(i);
            r_next  = gmul(gsq(r_next), INV_EXP[bit_idx] ? x : 8'h01);
        end
    end

    assign last_cycle = (k == 3'(STEPS_PER_CYCLE - 1));
    assign in_ready   = (state == IDLE);

    affine_transform u_affine (
        .b       (r_next),
        .encrypt (enc),
        .y       (affine_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= 8'h00;
            enc       <= 1'b0;
            r         <= 8'h01;
            k         <= 3'd7;
            out_valid <= 1'b0;
            byte_out  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x     <= byte_in;
                        enc   <= encrypt;
                        r     <= 8'h01;
                        k     <= 3'd7;
                        state <= CALC;
                    end
                end
                CALC: begin
                    r <= r_next;
                    k <= k - 3'(STEPS_PER_CYCLE);
                    if (last_cycle) begin
                        byte_out  <= affine_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_fwd_iter.sv
// tb/tb_sbox_fwd_iter.sv - self-checking bench for sbox_fwd_iter at every legal STEPS_PER_CYCLE
module tb_sbox_fwd_iter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] byte_in;
    logic       encrypt;
    logic       out_ready;

    logic       in_ready_w  [4];
    logic       out_valid_w [4];
    logic [7:0] byte_out_w  [4];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   stream_phase = 1'b0;
    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check8(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%h expected=%h at cycle %0d", name, inst, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0d expected=%0d at cycle %0d", name, inst, act, exp, cyc);
        end
    endtask

    // Carry-less product followed by polynomial long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int d = 14; d >= 8; d--) if (p[d]) p = p ^ (15'(9'h11B) << (d - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_inv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++) if (m_mul(a, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_aff(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int S   = 1 << g;
        localparam int LAT = 8 / S + 1;

        sbox_fwd_iter #(.STEPS_PER_CYCLE(S)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .byte_in   (byte_in),
            .encrypt   (encrypt),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .byte_out  (byte_out_w[g])
        );

        logic [7:0] exp_q [$];
        int         acc_q [$];
        logic [7:0] held;
        logic [7:0] exp_b;
        bit         pend;
        bit         exp_ov;
        int         last_acc;
        bit         have_last;
        int         stream_acc = 0;

        always @(negedge clk) begin
            if (reset) begin
                exp_q.delete();
                acc_q.delete();
                held      = 8'h00;
                have_last = 1'b0;
            end else begin
                pend   = (exp_q.size() > 0);
                exp_ov = pend && ((cyc - acc_q[0]) >= LAT);
                exp_b  = exp_ov ? exp_q[0] : held;
                check8("out_valid", g, {7'd0, out_valid_w[g]}, {7'd0, exp_ov});
                check8("in_ready", g, {7'd0, in_ready_w[g]}, {7'd0, !pend});
                check8("byte_out", g, byte_out_w[g], exp_b);
                if (in_valid && in_ready_w[g]) begin
                    if (stream_phase) begin
                        stream_acc++;
                        if (have_last) check_int("accept_interval", g, cyc - last_acc, LAT + 1);
                    end
                    last_acc  = cyc;
                    have_last = stream_phase;
                end
                if (exp_ov && out_ready) begin
                    held = exp_q.pop_front();
                    void'(acc_q.pop_front());
                end else if (!pend && in_valid) begin
                    exp_q.push_back(encrypt ? sbox_t[byte_in] : 8'h00);
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic txn(input logic [7:0] b, input logic e, output logic [7:0] res, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready_w[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_int("idle_wait", 0, n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        byte_in  = b;
        encrypt  = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid_w[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = byte_out_w[0];
    endtask

    logic [7:0] vin  [4] = '{8'h01, 8'h53, 8'h10, 8'hFF};
    logic [7:0] vexp [4] = '{8'h7C, 8'hED, 8'hCA, 8'h16};

    initial begin
        logic [7:0] res;
        logic [7:0] hold;
        int         lat;

        for (int i = 0; i < 256; i++) sbox_t[i] = m_aff(m_inv(8'(i)));
        reset = 1'b1; in_valid = 1'b0; byte_in = 8'h00; encrypt = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check8("rst_in_ready", 0, {7'd0, in_ready_w[0]}, 8'h01);
        check8("rst_out_valid", 0, {7'd0, out_valid_w[0]}, 8'h00);
        check8("rst_byte_out", 0, byte_out_w[0], 8'h00);

        txn(8'h00, 1'b1, res, lat);
        check8("s_of_00", 0, res, 8'h63);
        check_int("latency_00", 0, lat, 9);
        @(negedge clk);
        check8("one_cycle_pulse", 0, {7'd0, out_valid_w[0]}, 8'h00);

        for (int i = 0; i < 4; i++) begin
            txn(vin[i], 1'b1, res, lat);
            check8("vector", 0, res, vexp[i]);
            check_int("vector_latency", 0, lat, 9);
        end

        txn(8'h53, 1'b0, res, lat);
        check8("decrypt_zero", 0, res, 8'h00);
        check_int("decrypt_latency", 0, lat, 9);
        check8("or_merge", 0, res | 8'h50, 8'h50);

        @(posedge clk);
        #1 out_ready = 1'b0;
        txn(8'hC3, 1'b1, res, lat);
        check8("bp_value", 0, res, 8'h2E);
        hold = res;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            in_valid = (n == 1);
            byte_in  = 8'hAA;
            @(negedge clk);
            check8("bp_out_valid", 0, {7'd0, out_valid_w[0]}, 8'h01);
            check8("bp_byte_out", 0, byte_out_w[0], hold);
            check8("bp_in_ready", 0, {7'd0, in_ready_w[0]}, 8'h00);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check8("bp_release_valid", 0, {7'd0, out_valid_w[0]}, 8'h01);
        @(negedge clk);
        check8("bp_idle_valid", 0, {7'd0, out_valid_w[0]}, 8'h00);
        check8("bp_idle_ready", 0, {7'd0, in_ready_w[0]}, 8'h01);

        @(posedge clk);
        #1;
        in_valid = 1'b1; byte_in = 8'h53; encrypt = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check8("midcalc_out_valid", 0, {7'd0, out_valid_w[0]}, 8'h00);
        check8("midcalc_byte_out", 0, byte_out_w[0], 8'h00);
        check8("midcalc_in_ready", 0, {7'd0, in_ready_w[0]}, 8'h01);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check8("no_stale_output", 0, {7'd0, out_valid_w[0]}, 8'h00);
        end
        txn(8'h01, 1'b1, res, lat);
        check8("after_reset", 0, res, 8'h7C);

        for (int i = 0; i < 256; i++) begin
            txn(8'(i), 1'b1, res, lat);
            check8("sweep", 0, res, sbox_t[i]);
            check_int("sweep_latency", 0, lat, 9);
        end

        @(posedge clk);
        #1;
        stream_phase = 1'b1;
        in_valid = 1'b1;
        encrypt  = 1'b1;
        byte_in  = 8'h20;
        repeat (45) begin
            @(posedge clk);
            #1 byte_in = byte_in + 8'h1D;
        end
        in_valid = 1'b0;
        stream_phase = 1'b0;
        repeat (15) @(posedge clk);
        check_int("stream_accepts", 0, g_dut[0].stream_acc, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
